// File: rtl/sigmoid_rr_scheduler.sv
// sigmoid_rr_scheduler: round-robin sharing of one sigmoid_approx datapath.
// Define SIGMOID_SCHED_STATS_EN to add the stat_grants/stat_stall counters.

module sigmoid_approx #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);
    // Breakpoints are raw codes; the 65536 ceiling needs at least 18 bits.
    if (DATA_WIDTH < 18 || FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_cfg
        $error("sigmoid_approx: unsupported DATA_WIDTH/FRAC_WIDTH");
    end

    localparam logic signed [DATA_WIDTH-1:0] POS_SAT = DATA_WIDTH'(4096);
    localparam logic signed [DATA_WIDTH-1:0] NEG_SAT = -DATA_WIDTH'(4096);
    localparam logic signed [DATA_WIDTH-1:0] HALF    = DATA_WIDTH'(32768);
    localparam logic signed [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(65536);

    logic signed [DATA_WIDTH-1:0] xs;

    assign xs = $signed(x);

    always_comb begin
        y = (xs >>> 2) + HALF;
        if (xs >= POS_SAT) begin
            y = ONE;
        end else if (xs <= NEG_SAT) begin
            y = '0;
        end
    end
endmodule

module sigmoid_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = 16,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_y,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          busy
`ifdef SIGMOID_SCHED_STATS_EN
    ,
    output logic [31:0]                   stat_grants,
    output logic [31:0]                   stat_stall
`endif
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       id_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic [DATA_WIDTH-1:0] sig_y;
    logic [DATA_WIDTH-1:0] x_arr [NUM_REQ];
    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic [ID_W-1:0]       ptr_next;
    logic                  rsp_hs;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign x_arr[g] = req_x[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W-1:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign rsp_hs   = (state_q == RESP) && rsp_ready;
    assign ptr_next = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (win_found) state_d = CALC;
            CALC: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    sigmoid_approx #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH)
    ) u_sig (
        .x(x_q),
        .y(sig_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            x_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_found) begin
                x_q  <= x_arr[win_id];
                id_q <= win_id;
            end
            if (state_q == CALC) begin
                rsp_y     <= sig_y;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
            if (rsp_hs) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= ptr_next;
            end
        end
    end

`ifdef SIGMOID_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            if (rsp_hs && stat_grants != '1) begin
                stat_grants <= stat_grants + 32'd1;
            end
            if (state_q == RESP && !rsp_ready && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// Directed testbench for sigmoid_rr_scheduler: transfer table, round-robin,
// backpressure, pointer wrap and mid-transaction reset sequences.

module tb_sigmoid_rr_scheduler;
    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_x;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_y;
    logic [1:0]   rsp_id;
    logic         busy;
`ifdef SIGMOID_SCHED_STATS_EN
    logic [31:0]  stat_grants;
    logic [31:0]  stat_stall;
`endif

    int n_chk;
    int n_fail;

    sigmoid_rr_scheduler #(
        .NUM_REQ(4),
        .DATA_WIDTH(32),
        .FRAC_WIDTH(16),
        .ID_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x(req_x),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_y(rsp_y),
        .rsp_id(rsp_id),
        .busy(busy)
`ifdef SIGMOID_SCHED_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated transaction; entered at a negedge with the DUT idle.
    task automatic single(input int id, input logic [31:0] x,
                          input logic [31:0] exp_y, input string nm);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        req_x[id*32 +: 32] = x;
        req_valid = oh;
        rsp_ready = 1'b1;
        #1;
        chk($sformatf("%s ready", nm), 64'(req_ready), 64'(oh));
        @(negedge clk);
        req_valid = '0;
        chk($sformatf("%s calc", nm), {62'd0, busy, rsp_valid}, 64'd2);
        @(negedge clk);
        chk($sformatf("%s valid", nm), 64'(rsp_valid), 64'd1);
        chk($sformatf("%s y", nm), 64'(rsp_y), 64'(exp_y));
        chk($sformatf("%s id", nm), 64'(rsp_id), 64'(id));
        @(negedge clk);
        chk($sformatf("%s idle", nm), {62'd0, busy, rsp_valid}, 64'd0);
    endtask

    initial begin
        int got;
        int extra;
        int ids[5];
        int cyc[5];
        logic [31:0] ys[5];
        logic [31:0] rr_y[4];

        n_chk = 0;
        n_fail = 0;
        req_x = '0;
        vt[0] = '{0, 32'd0,         32'd32768};
        vt[1] = '{1, 32'd4096,      32'd65536};
        vt[2] = '{2, 32'hFFFFF000,  32'd0};
        vt[3] = '{3, 32'd400,       32'd32868};
        vt[4] = '{0, 32'hFFFFFE70,  32'd32668};
        vt[5] = '{1, 32'd4095,      32'd33791};
        vt[6] = '{2, 32'hFFFFF001,  32'd31744};
        vt[7] = '{3, 32'h7FFFFFFF,  32'd65536};
        vt[8] = '{0, 32'hFFFFFFFF,  32'd32767};

        do_reset();
        #1;
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_y", 64'(rsp_y), 64'd0);
        chk("rst rsp_id", 64'(rsp_id), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
`ifdef SIGMOID_SCHED_STATS_EN
        chk("rst grants", 64'(stat_grants), 64'd0);
        chk("rst stall", 64'(stat_stall), 64'd0);
`endif
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            single(vt[i].id, vt[i].x, vt[i].y, $sformatf("vec%0d", i));
        end

        // Valid pulse withdrawn before any clock edge.
        req_valid = 4'b0100;
        #2;
        req_valid = '0;
        @(negedge clk);
        chk("drop busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("drop rsp", {62'd0, busy, rsp_valid}, 64'd0);

        // All requesters valid continuously.
        do_reset();
        req_x[31:0]   = 32'd0;
        req_x[63:32]  = 32'd400;
        req_x[95:64]  = 32'hFFFFFE70;
        req_x[127:96] = 32'd4096;
        rr_y[0] = 32'd32768;
        rr_y[1] = 32'd32868;
        rr_y[2] = 32'd32668;
        rr_y[3] = 32'd65536;
        req_valid = 4'hF;
        got = 0;
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (got < 5) begin
                    ids[got] = int'(rsp_id);
                    ys[got] = rsp_y;
                    cyc[got] = c;
                    got++;
                    if (got == 5) req_valid = '0;
                end else begin
                    extra++;
                end
            end
        end
        chk("rr count", 64'(got), 64'd5);
        chk("rr extra", 64'(extra), 64'd0);
        if (got == 5) begin
            chk("rr first lat", 64'(cyc[0]), 64'd1);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("rr id%0d", k), 64'(ids[k]), 64'(k % 4));
                chk($sformatf("rr y%0d", k), 64'(ys[k]), 64'(rr_y[k % 4]));
                if (k > 0) begin
                    chk($sformatf("rr gap%0d", k),
                        64'(cyc[k] - cyc[k-1]), 64'd3);
                end
            end
        end

        // Backpressure: five stalled RESP cycles.
        do_reset();
        req_x[95:64] = 32'd400;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'hF;
            #1;
            chk($sformatf("bp valid%0d", k), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp y%0d", k), 64'(rsp_y), 64'd32868);
            chk($sformatf("bp id%0d", k), 64'(rsp_id), 64'd2);
            chk($sformatf("bp ready%0d", k), 64'(req_ready), 64'd0);
            chk($sformatf("bp busy%0d", k), 64'(busy), 64'd1);
            req_valid = '0;
            @(negedge clk);
        end
`ifdef SIGMOID_SCHED_STATS_EN
        chk("bp stall", 64'(stat_stall), 64'd5);
        chk("bp grants0", 64'(stat_grants), 64'd0);
`endif
        chk("bp held", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release", {62'd0, busy, rsp_valid}, 64'd0);
`ifdef SIGMOID_SCHED_STATS_EN
        chk("bp grants1", 64'(stat_grants), 64'd1);
        chk("bp stall end", 64'(stat_stall), 64'd5);
`endif

        // Pointer wrap: grant 3 moves rr_ptr to 0, then 0 beats 3.
        single(3, 32'd0, 32'd32768, "wrap3");
        req_x[31:0] = 32'd4096;
        req_valid = 4'b1001;
        #1;
        chk("wrap ready0", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("wrap id0", 64'(rsp_id), 64'd0);
        chk("wrap y0", 64'(rsp_y), 64'd65536);
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        chk("wrap ready3", 64'(req_ready), 64'd8);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("wrap id3", 64'(rsp_id), 64'd3);
        @(negedge clk);

        // Reset while in CALC.
        req_x[63:32] = 32'd400;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        chk("rc calc", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rc busy", 64'(busy), 64'd0);
        chk("rc valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) extra++;
        end
        chk("rc no rsp", 64'(extra), 64'd0);

        // Reset while a result is being presented.
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("rr resp valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rr resp drop", {62'd0, busy, rsp_valid}, 64'd0);
        chk("rr resp y", 64'(rsp_y), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rr resp after", 64'(rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
